// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage = operand register (S1) -> 32-bit ALU -> OUT_DEPTH-entry output FIFO.
// Valid/ready on both sides lets decode and writeback stall independently.
// Optional feature macro ALU_OVF_TRAP_EN: add/sub overflow raises out_exc and replaces the result with a code.
module alu_exec_stage #(
    parameter int TAG_W     = 5,
    parameter int OUT_DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_opA,
    input  logic [31:0]      in_opB,
    input  logic [4:0]       in_opcode,
    input  logic [4:0]       in_shamt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_ne,
    output logic             out_lt,
    output logic             out_ovf,
    output logic             out_exc,
    output logic [TAG_W-1:0] out_tag
);
    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam int EW = TAG_W + 36;

    logic             rdy_q, rdy_d;
    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      opa_q, opa_d, opb_q, opb_d;
    logic [4:0]       opc_q, opc_d, shamt_q, shamt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [EW-1:0]    mem_q [OUT_DEPTH];
    logic [EW-1:0]    mem_d [OUT_DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [31:0]      sum, diff, alu_res;
    logic             alu_ne, alu_lt, alu_ovf, alu_exc;
    logic             pop, move, accept, push, pull;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // in_ready depends only on state, flush and out_ready; never on in_valid
    assign out_valid = count_q != '0;
    assign pop       = out_valid & out_ready;
    assign move      = s1_valid_q & ((count_q < CW'(OUT_DEPTH)) | pop);
    assign in_ready  = rdy_q & ~flush & (~s1_valid_q | move);
    assign accept    = in_valid & in_ready;
    assign push      = move & ~flush;
    assign pull      = pop & ~flush;
    assign {out_tag, out_exc, out_ovf, out_lt, out_ne, out_result} = mem_q[rd_ptr_q];

    // ALU on the S1 operands; flags not defined for an opcode stay 0, illegal opcodes give all zeros
    always_comb begin
        sum     = opa_q + opb_q;
        diff    = opa_q - opb_q;
        alu_res = '0;
        alu_ne  = 1'b0;
        alu_lt  = 1'b0;
        alu_ovf = 1'b0;
        alu_exc = 1'b0;
        case (opc_q)
            5'd0: begin
                alu_res = sum;
                alu_ovf = (opa_q[31] == opb_q[31]) & (sum[31] != opa_q[31]);
            end
            5'd1: begin
                alu_res = diff;
                alu_ne  = opa_q != opb_q;
                alu_lt  = $signed(opa_q) < $signed(opb_q);
                alu_ovf = (opa_q[31] != opb_q[31]) & (diff[31] != opa_q[31]);
            end
            5'd2:    alu_res = opa_q & opb_q;
            5'd3:    alu_res = opa_q | opb_q;
            5'd4:    alu_res = opa_q << shamt_q;
            5'd5:    alu_res = $unsigned($signed(opa_q) >>> shamt_q);
            default: alu_res = '0;
        endcase
`ifdef ALU_OVF_TRAP_EN
        alu_exc = alu_ovf;
        if (alu_exc) alu_res = (opc_q == 5'd0) ? 32'd1 : 32'd3;
`endif
    end

    // next state for S1 and the FIFO; flush overrides accept, push and pop
    always_comb begin
        rdy_d      = 1'b1;
        s1_valid_d = flush ? 1'b0 : accept ? 1'b1 : move ? 1'b0 : s1_valid_q;
        opa_d      = accept ? in_opA : opa_q;
        opb_d      = accept ? in_opB : opb_q;
        opc_d      = accept ? in_opcode : opc_q;
        shamt_d    = accept ? in_shamt : shamt_q;
        tag_d      = accept ? in_tag : tag_q;
        mem_d      = mem_q;
        if (push) mem_d[wr_ptr_q] = {tag_q, alu_exc, alu_ovf, alu_lt, alu_ne, alu_res};
        wr_ptr_d   = flush ? '0 : push ? nxt(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = flush ? '0 : pull ? nxt(rd_ptr_q) : rd_ptr_q;
        count_d    = flush ? '0 : (push & ~pull) ? count_q + 1'b1 :
                     (pull & ~push) ? count_q - 1'b1 : count_q;
    end

    // state registers; reset clears everything and holds in_ready low until one edge after release
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdy_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            opa_q      <= '0;
            opb_q      <= '0;
            opc_q      <= '0;
            shamt_q    <= '0;
            tag_q      <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            rdy_q      <= rdy_d;
            s1_valid_q <= s1_valid_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            opc_q      <= opc_d;
            shamt_q    <= shamt_d;
            tag_q      <= tag_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed vectors with a scoreboard queue and an independent output monitor.
module tb_alu_exec_stage;
    logic        clock = 1'b0, reset = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_opA = '0, in_opB = '0;
    logic [4:0]  in_opcode = '0, in_shamt = '0, in_tag = '0;
    logic        in_ready, out_valid, out_ne, out_lt, out_ovf, out_exc;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    int          total = 0, bad = 0, cyc = 0;

    typedef struct packed {
        logic [31:0] r;
        logic        ne, lt, ovf, exc;
        logic [4:0]  tag;
    } exp_t;
    exp_t q[$];

`ifdef ALU_OVF_TRAP_EN
    localparam logic [31:0] ADD_OVF_R = 32'd1, SUB_OVF_R = 32'd3;
    localparam logic        EXC = 1'b1;
`else
    localparam logic [31:0] ADD_OVF_R = 32'h8000_0000, SUB_OVF_R = 32'h7FFF_FFFF;
    localparam logic        EXC = 1'b0;
`endif

    alu_exec_stage dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_opA(in_opA), .in_opB(in_opB),
        .in_opcode(in_opcode), .in_shamt(in_shamt), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_ne(out_ne), .out_lt(out_lt), .out_ovf(out_ovf), .out_exc(out_exc), .out_tag(out_tag)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [31:0] r, input logic ne, lt, ovf, exc, input logic [4:0] tag);
        return {r, ne, lt, ovf, exc, tag};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // issue one op (called just after a rising edge); expected value is queued when the handshake is seen
    task automatic send(input logic [31:0] a, b, input logic [4:0] opc, sh, tag, input exp_t e);
        int n = 0;
        in_valid = 1'b1; in_opA = a; in_opB = b; in_opcode = opc; in_shamt = sh; in_tag = tag;
        @(negedge clock);
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL send_timeout tag=%0d got in_ready=0 exp 1", tag);
        end else q.push_back(e);
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain got remaining=%0d exp 0", q.size());
            q.delete();
        end
        @(posedge clock);
        #1;
    endtask

    // monitor: every consumed head entry is compared against the oldest expectation
    always @(negedge clock) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_out got result=%h tag=%0d exp none", out_result, out_tag);
            end else begin
                e = q.pop_front();
                chk("result", out_result, e.r);
                chk("ne_lt_ovf_exc_tag", {out_ne, out_lt, out_ovf, out_exc, out_tag},
                    {e.ne, e.lt, e.ovf, e.exc, e.tag});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        #1 reset = 1'b1;
        @(posedge clock); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_result", out_result, 0);
        chk("rst_tag", out_tag, 0);
        reset = 1'b0;
        @(negedge clock) chk("ready_before_edge", in_ready, 0);
        @(posedge clock); #1;
        @(negedge clock) chk("ready_after_edge", in_ready, 1);
        @(posedge clock); #1;

        // single add, latency check
        out_ready = 1'b1;
        send(32'd7, 32'd5, 5'd0, 5'd0, 5'd3, mk(32'd12, 0, 0, 0, 0, 5'd3));
        @(posedge clock);
        @(negedge clock) chk("latency_valid", out_valid, 1);
        @(posedge clock); #1;

        // overflow and flag cases, back to back
        send(32'h8000_0000, 32'd1, 5'd1, 5'd0, 5'd4, mk(SUB_OVF_R, 1, 1, 1, EXC, 5'd4));
        send(32'h7FFF_FFFF, 32'd1, 5'd0, 5'd0, 5'd5, mk(ADD_OVF_R, 0, 0, 1, EXC, 5'd5));
        send(32'd5, 32'd5, 5'd1, 5'd0, 5'd6, mk(32'd0, 0, 0, 0, 0, 5'd6));
        send(32'hFF00_FF00, 32'h0FF0_0FF0, 5'd2, 5'd0, 5'd7, mk(32'h0F00_0F00, 0, 0, 0, 0, 5'd7));
        send(32'd3, 32'd9, 5'd1, 5'd0, 5'd8, mk(32'hFFFF_FFFA, 1, 1, 0, 0, 5'd8));
        drain();

        // backpressure: two in FIFO plus one in S1, then in_ready must drop
        out_ready = 1'b0;
        send(32'h1000_0000, 32'd0, 5'd0, 5'd0, 5'd10, mk(32'h1000_0000, 0, 0, 0, 0, 5'd10));
        send(32'h0000_F0F0, 32'h0000_0F0F, 5'd3, 5'd0, 5'd11, mk(32'h0000_FFFF, 0, 0, 0, 0, 5'd11));
        send(32'd1, 32'd0, 5'd4, 5'd4, 5'd12, mk(32'h10, 0, 0, 0, 0, 5'd12));
        @(negedge clock) chk("full_in_ready", in_ready, 0);
        repeat (3) @(negedge clock);
        chk("hold_valid", out_valid, 1);
        chk("hold_result", out_result, 32'h1000_0000);
        chk("hold_tag", out_tag, 10);
        @(posedge clock); #1 out_ready = 1'b1;
        send(32'h8000_0000, 32'd0, 5'd5, 5'd31, 5'd13, mk(32'hFFFF_FFFF, 0, 0, 0, 0, 5'd13));
        drain();

        // sustained throughput from full: one in and one out per cycle, pointers wrap
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(32'(i), 32'd50, 5'd3, 5'd0, 5'(16 + i), mk(32'(i) | 32'd50, 0, 0, 0, 0, 5'(16 + i)));
        out_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 8; i++)
            send(32'(i), 32'd100, 5'd0, 5'd0, 5'(i), mk(32'(i + 100), 0, 0, 0, 0, 5'(i)));
        chk("throughput_cycles", 32'(cyc - c0), 8);
        drain();

        // flush with FIFO holding two and a new op offered
        out_ready = 1'b0;
        send(32'd1, 32'd1, 5'd0, 5'd0, 5'd20, mk(32'd2, 0, 0, 0, 0, 5'd20));
        send(32'd2, 32'd2, 5'd0, 5'd0, 5'd21, mk(32'd4, 0, 0, 0, 0, 5'd21));
        @(posedge clock); #1;
        flush = 1'b1; in_valid = 1'b1; in_opA = 32'd9; in_opB = 32'd9; in_opcode = 5'd0; in_tag = 5'd22;
        @(negedge clock) chk("flush_in_ready", in_ready, 0);
        @(posedge clock); #1;
        flush = 1'b0; in_valid = 1'b0;
        q.delete();
        @(negedge clock) chk("flush_out_valid", out_valid, 0);
        @(posedge clock); #1 out_ready = 1'b1;
        send(32'hFFFF_FFFF, 32'd1, 5'd7, 5'd3, 5'd9, mk(32'd0, 0, 0, 0, 0, 5'd9));
        repeat (4) @(negedge clock);
        drain();

        // asynchronous reset mid-stream with the FIFO full
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(32'd1, 32'(i), 5'd0, 5'd0, 5'(24 + i), mk(32'(i + 1), 0, 0, 0, 0, 5'(24 + i)));
        #2 reset = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        q.delete();
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        chk("postrst_in_ready", in_ready, 1);
        chk("postrst_out_valid", out_valid, 0);
        @(posedge clock); #1 out_ready = 1'b1;
        send(32'd1, 32'd2, 5'd0, 5'd0, 5'd1, mk(32'd3, 0, 0, 0, 0, 5'd1));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
